// File: rtl/disp_char.sv
// Seven-segment glyph pixel generator for one 32x32 text-overlay cell.
// Decodes the glyph into a segment mask, tests the pixel against each
// segment rectangle and registers the result with one cycle of latency.
module disp_char (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] char_sel,
   input  logic [5:0] char_row,
   input  logic [5:0] char_col,
   output logic       out
);

   localparam int unsigned SEG_W = 7;

   // Segment rectangles (inclusive bounds), segments ordered a..g
   localparam logic [5:0] A_R0 = 6'd2;
   localparam logic [5:0] A_R1 = 6'd5;
   localparam logic [5:0] A_C0 = 6'd6;
   localparam logic [5:0] A_C1 = 6'd25;

   localparam logic [5:0] B_R0 = 6'd2;
   localparam logic [5:0] B_R1 = 6'd15;
   localparam logic [5:0] B_C0 = 6'd22;
   localparam logic [5:0] B_C1 = 6'd25;

   localparam logic [5:0] C_R0 = 6'd16;
   localparam logic [5:0] C_R1 = 6'd29;
   localparam logic [5:0] C_C0 = 6'd22;
   localparam logic [5:0] C_C1 = 6'd25;

   localparam logic [5:0] D_R0 = 6'd26;
   localparam logic [5:0] D_R1 = 6'd29;
   localparam logic [5:0] D_C0 = 6'd6;
   localparam logic [5:0] D_C1 = 6'd25;

   localparam logic [5:0] E_R0 = 6'd16;
   localparam logic [5:0] E_R1 = 6'd29;
   localparam logic [5:0] E_C0 = 6'd6;
   localparam logic [5:0] E_C1 = 6'd9;

   localparam logic [5:0] F_R0 = 6'd2;
   localparam logic [5:0] F_R1 = 6'd15;
   localparam logic [5:0] F_C0 = 6'd6;
   localparam logic [5:0] F_C1 = 6'd9;

   localparam logic [5:0] G_R0 = 6'd14;
   localparam logic [5:0] G_R1 = 6'd17;
   localparam logic [5:0] G_C0 = 6'd6;
   localparam logic [5:0] G_C1 = 6'd25;

   logic [SEG_W-1:0] seg_mask;   // lit segments, bit order g f e d c b a
   logic [SEG_W-1:0] seg_hit;    // pixel lies inside segment rectangle
   logic             outside;    // pixel beyond the 32x32 cell
   logic             out_d;
   logic             out_q;

   // Inclusive rectangle membership test
   function automatic logic in_box(
      input logic [5:0] r,
      input logic [5:0] c,
      input logic [5:0] r0,
      input logic [5:0] r1,
      input logic [5:0] c0,
      input logic [5:0] c1
   );
      return (r >= r0) && (r <= r1) && (c >= c0) && (c <= c1);
   endfunction

   // Glyph code to segment mask
   always_comb begin
      seg_mask = 7'b000_0000;
      case (char_sel)
         5'd0:    seg_mask = 7'b011_1111;
         5'd1:    seg_mask = 7'b000_0110;
         5'd2:    seg_mask = 7'b101_1011;
         5'd3:    seg_mask = 7'b100_1111;
         5'd4:    seg_mask = 7'b110_0110;
         5'd5:    seg_mask = 7'b110_1101;
         5'd6:    seg_mask = 7'b111_1101;
         5'd7:    seg_mask = 7'b000_0111;
         5'd8:    seg_mask = 7'b111_1111;
         5'd9:    seg_mask = 7'b110_1111;
         5'd10:   seg_mask = 7'b111_0111;
         5'd11:   seg_mask = 7'b111_1100;
         5'd12:   seg_mask = 7'b011_1001;
         5'd13:   seg_mask = 7'b101_1110;
         5'd14:   seg_mask = 7'b111_1001;
         5'd15:   seg_mask = 7'b111_0001;
         5'd16:   seg_mask = 7'b100_0000;
         default: seg_mask = 7'b000_0000;
      endcase
   end

   // Pixel position against every segment rectangle, then combine with mask
   always_comb begin
      seg_hit    = 7'b000_0000;
      seg_hit[0] = in_box(char_row, char_col, A_R0, A_R1, A_C0, A_C1);
      seg_hit[1] = in_box(char_row, char_col, B_R0, B_R1, B_C0, B_C1);
      seg_hit[2] = in_box(char_row, char_col, C_R0, C_R1, C_C0, C_C1);
      seg_hit[3] = in_box(char_row, char_col, D_R0, D_R1, D_C0, D_C1);
      seg_hit[4] = in_box(char_row, char_col, E_R0, E_R1, E_C0, E_C1);
      seg_hit[5] = in_box(char_row, char_col, F_R0, F_R1, F_C0, F_C1);
      seg_hit[6] = in_box(char_row, char_col, G_R0, G_R1, G_C0, G_C1);
      // Rows/cols 32-63 have bit 5 set; rectangles already exclude them,
      // the explicit gate keeps the intent obvious.
      outside    = char_row[5] | char_col[5];
      out_d      = ~outside & (|(seg_mask & seg_hit));
   end

   // Output pixel register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= 1'b0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_disp_char.sv
// Bench for disp_char: directed scenarios plus randomized pixels checked
// against a table-driven model of the glyph geometry.
module tb_disp_char;

   logic       clk;
   logic       rst;
   logic [4:0] char_sel;
   logic [5:0] char_row;
   logic [5:0] char_col;
   logic       out;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   disp_char dut (
      .clk      (clk),
      .rst      (rst),
      .char_sel (char_sel),
      .char_row (char_row),
      .char_col (char_col),
      .out      (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Segment masks per glyph (bit order g f e d c b a), codes 0-16
   localparam bit [6:0] MASK_TBL [17] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h40
   };
   // Segment rectangles, index 0..6 = a..g
   localparam int ROW_LO [7] = '{ 2,  2, 16, 26, 16,  2, 14};
   localparam int ROW_HI [7] = '{ 5, 15, 29, 29, 29, 15, 17};
   localparam int COL_LO [7] = '{ 6, 22, 22,  6,  6,  6,  6};
   localparam int COL_HI [7] = '{25, 25, 25, 25,  9,  9, 25};

   // Reference pixel value
   function automatic logic ref_pix(input int sel, input int row, input int col);
      bit [6:0] m;
      if (row >= 32 || col >= 32) return 1'b0;
      if (sel > 16) return 1'b0;
      m = MASK_TBL[sel];
      for (int s = 0; s < 7; s++) begin
         if (m[s] && row >= ROW_LO[s] && row <= ROW_HI[s] &&
             col >= COL_LO[s] && col <= COL_HI[s])
            return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      char_sel = 5'd8; char_row = 6'd15; char_col = 6'd15;
      #1;
      chk_cnt++;
      if (out !== 1'b0) $display("FAIL reset_async: out=%b expected 0", out);
      else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++;
      if (out !== 1'b0) $display("FAIL reset_held: out=%b expected 0", out);
      else pass_cnt++;
      rst = 1'b0;
      @(posedge clk); #1;
      chk_cnt++;
      if (out !== 1'b1) $display("FAIL reset_release: out=%b expected 1", out);
      else pass_cnt++;
   endtask

   task automatic test_latency();
      char_sel = 5'd8; char_row = 6'd15; char_col = 6'd15;
      @(posedge clk); #1;
      char_row = 6'd0; char_col = 6'd0;
      chk_cnt++;
      if (out !== 1'b1) $display("FAIL latency_k: out=%b expected 1", out);
      else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++;
      if (out !== 1'b0) $display("FAIL latency_k1: out=%b expected 0", out);
      else pass_cnt++;
   endtask

   task automatic test_segments();
      // sel, row, col, expected
      int vec [12][4] = '{
         '{ 7,  3, 10, 1}, '{ 1,  3, 10, 0},
         '{16, 15, 10, 1}, '{16,  3, 10, 0},
         '{20, 15, 15, 0}, '{20,  3, 10, 0},
         '{ 8, 32, 15, 0}, '{ 8, 15, 40, 0},
         '{ 8, 29, 25, 1}, '{ 8,  1, 10, 0},
         '{ 8, 15,  5, 0}, '{ 8, 15, 26, 0}
      };
      for (int i = 0; i < 12; i++) begin
         char_sel = 5'(vec[i][0]);
         char_row = 6'(vec[i][1]);
         char_col = 6'(vec[i][2]);
         @(posedge clk); #1;
         chk_cnt++;
         if (out !== 1'(vec[i][3]))
            $display("FAIL segment_vec%0d: sel=%0d row=%0d col=%0d out=%b expected %0d",
                     i, vec[i][0], vec[i][1], vec[i][2], out, vec[i][3]);
         else pass_cnt++;
      end
   endtask

   task automatic test_sweep();
      // Row 10 col 23 lies in segment b only; lit exactly for glyphs owning b
      bit [16:0] b_lit = 17'b0_0010_0111_1001_1111;
      for (int s = 0; s <= 16; s++) begin
         char_sel = 5'(s); char_row = 6'd10; char_col = 6'd23;
         for (int h = 0; h < 2; h++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (out !== b_lit[s])
               $display("FAIL sweep_b sel=%0d cyc=%0d: out=%b expected %b", s, h, out, b_lit[s]);
            else pass_cnt++;
         end
      end
      // Row 15 col 23 sits in both b and g
      for (int s = 0; s <= 16; s++) begin
         char_sel = 5'(s); char_row = 6'd15; char_col = 6'd23;
         for (int h = 0; h < 2; h++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (out !== ref_pix(s, 15, 23))
               $display("FAIL sweep_bg sel=%0d cyc=%0d: out=%b expected %b",
                        s, h, out, ref_pix(s, 15, 23));
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_random();
      int   sel, row, col;
      logic exp;
      for (int i = 0; i < 600; i++) begin
         sel = int'($urandom_range(0, 31));
         if (sel > 20) sel = int'($urandom_range(0, 16));
         row = ($urandom % 5 == 0) ? int'($urandom_range(32, 63)) : int'($urandom_range(0, 31));
         col = ($urandom % 5 == 0) ? int'($urandom_range(32, 63)) : int'($urandom_range(0, 31));
         char_sel = 5'(sel); char_row = 6'(row); char_col = 6'(col);
         rst = ($urandom % 30 == 0);
         #1;
         if (rst) begin
            chk_cnt++;
            if (out !== 1'b0) $display("FAIL random_async_rst%0d: out=%b expected 0", i, out);
            else pass_cnt++;
         end
         @(posedge clk); #1;
         exp = rst ? 1'b0 : ref_pix(sel, row, col);
         chk_cnt++;
         if (out !== exp)
            $display("FAIL random%0d: sel=%0d row=%0d col=%0d rst=%b out=%b expected %b",
                     i, sel, row, col, rst, out, exp);
         else pass_cnt++;
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      // Fresh inputs every cycle, no idle cycles between pixels
      int sel [8] = '{8, 8, 1, 16, 0, 12, 4, 8};
      int row [8] = '{3, 28, 20, 16, 20, 20, 4, 0};
      int col [8] = '{6, 25, 23, 25, 7, 24, 24, 31};
      for (int i = 0; i < 8; i++) begin
         char_sel = 5'(sel[i]); char_row = 6'(row[i]); char_col = 6'(col[i]);
         @(posedge clk); #1;
         chk_cnt++;
         if (out !== ref_pix(sel[i], row[i], col[i]))
            $display("FAIL b2b%0d: out=%b expected %b", i, out, ref_pix(sel[i], row[i], col[i]));
         else pass_cnt++;
      end
   endtask

   initial begin
      rst = 1'b1;
      char_sel = 5'd0; char_row = 6'd0; char_col = 6'd0;
      test_reset();
      test_latency();
      test_segments();
      test_sweep();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
